// File: rtl/cl_aes_ocl_engine_if.sv
// AXI-Lite register bus between the OCL register slice and the AES engine front-end.
interface cl_aes_ocl_engine_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/cl_aes_ocl_engine.sv
// AXI-Lite front-end for NUM_CH external aes_256 cores: per-channel plaintext, key,
// start, busy/done status, captured result and completed-operation count.
module cl_aes_ocl_engine #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned AES_LAT   = 30,
    parameter logic [31:0] UNMAP_VAL = 32'hDEAD_DEAD
) (
    input  logic                  clk_main_a0,
    input  logic                  rst_main_n,
    cl_aes_ocl_engine_if.slave    ocl,
    output logic [NUM_CH*128-1:0] core_state,
    output logic [NUM_CH*256-1:0] core_key,
    input  logic [NUM_CH*128-1:0] core_out,
    output logic [NUM_CH-1:0]     ch_done,
    output logic [15:0]           vled
);

    localparam int unsigned      CNT_W    = (AES_LAT > 1) ? $clog2(AES_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_LAT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} ch_state_t;

    ch_state_t          fsm      [NUM_CH];
    logic [CNT_W-1:0]   lat_cnt  [NUM_CH];
    logic [127:0]       state_q  [NUM_CH];
    logic [255:0]       key_q    [NUM_CH];
    logic [127:0]       result_q [NUM_CH];
    logic [31:0]        opcnt_q  [NUM_CH];

    logic               wr_active;
    logic               bvalid_q;
    logic [15:0]        wr_addr;
    logic               wr_fire;
    logic [5:0]         wr_word;
    logic [NUM_CH-1:0]  ch_wsel;

    logic               ar_q;
    logic               rvalid_q;
    logic [15:0]        rd_addr;
    logic [31:0]        rdata_q;
    logic [31:0]        rd_val;
    logic [5:0]         rd_word;

    // The bvalid term keeps a still-asserted wvalid from landing a second write
    assign wr_fire     = wr_active & ocl.wvalid & ~bvalid_q;
    assign wr_word     = wr_addr[7:2];
    assign ocl.awready = ~wr_active;
    assign ocl.wready  = wr_fire;
    assign ocl.bvalid  = bvalid_q;
    assign ocl.bresp   = 2'b00;

    assign rd_word     = rd_addr[7:2];
    assign ocl.arready = ~ar_q & ~rvalid_q;
    assign ocl.rvalid  = rvalid_q;
    assign ocl.rdata   = rdata_q;
    assign ocl.rresp   = 2'b00;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign core_state[g*128 +: 128] = state_q[g];
        assign core_key[g*256 +: 256]   = key_q[g];
        assign ch_done[g]               = (fsm[g] == ST_DONE);
        assign ch_wsel[g] = wr_fire && (wr_addr[15:12] == 4'd0) && (wr_addr[11:8] == 4'(g));
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_active <= 1'b0;
            bvalid_q  <= 1'b0;
            wr_addr   <= '0;
        end else begin
            if (!wr_active && ocl.awvalid) begin
                wr_active <= 1'b1;
                wr_addr   <= ocl.awaddr[15:0];
            end else if (bvalid_q && ocl.bready) begin
                wr_active <= 1'b0;
            end
            if (wr_fire) begin
                bvalid_q <= 1'b1;
            end else if (bvalid_q && ocl.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // NOTE: the register arrays are reset because software must see zeroed
    // STATE/KEY/RESULT/OPCNT after any reset, including one mid-operation.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                fsm[c]      <= ST_IDLE;
                lat_cnt[c]  <= '0;
                state_q[c]  <= '0;
                key_q[c]    <= '0;
                result_q[c] <= '0;
                opcnt_q[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (fsm[c])
                    ST_RUN: begin
                        // Start and STATE/KEY writes are ignored here so core inputs stay stable
                        if (lat_cnt[c] == CNT_LAST) begin
                            result_q[c] <= core_out[c*128 +: 128];
                            opcnt_q[c]  <= opcnt_q[c] + 32'd1;
                            fsm[c]      <= ST_DONE;
                        end else begin
                            lat_cnt[c] <= lat_cnt[c] + 1'b1;
                        end
                    end
                    default: begin
                        if (ch_wsel[c] && wr_word == 6'h00 && ocl.wstrb[0] && ocl.wdata[0]) begin
                            fsm[c]     <= ST_RUN;
                            lat_cnt[c] <= '0;
                        end
                        for (int b = 0; b < 4; b++) begin
                            if (ch_wsel[c] && ocl.wstrb[b]) begin
                                if (wr_word[5:2] == 4'h1)
                                    state_q[c][{wr_word[1:0], 2'(b), 3'b000} +: 8] <= ocl.wdata[b*8 +: 8];
                                if (wr_word[5:3] == 3'h1)
                                    key_q[c][{wr_word[2:0], 2'(b), 3'b000} +: 8] <= ocl.wdata[b*8 +: 8];
                            end
                        end
                    end
                endcase
            end
        end
    end

    // NOTE: rd_val gets a default before any branch so the mux cannot infer a latch.
    always_comb begin
        rd_val = UNMAP_VAL;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_addr[15:12] == 4'd0 && rd_addr[11:8] == 4'(c)) begin
                case (rd_word) inside
                    6'h00:          rd_val = {30'd0, fsm[c] == ST_DONE, fsm[c] == ST_RUN};
                    [6'h04:6'h07]:  rd_val = state_q[c][{rd_word[1:0], 5'b00000} +: 32];
                    [6'h08:6'h0F]:  rd_val = key_q[c][{rd_word[2:0], 5'b00000} +: 32];
                    [6'h10:6'h13]:  rd_val = result_q[c][{rd_word[1:0], 5'b00000} +: 32];
                    6'h14:          rd_val = opcnt_q[c];
                    default:        rd_val = UNMAP_VAL;
                endcase
            end
        end
    end

    // Address accepted at T is registered in ar_q at T+1 and presented as rvalid at T+2
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            ar_q     <= 1'b0;
            rd_addr  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else if (ocl.arvalid && !ar_q && !rvalid_q) begin
            ar_q    <= 1'b1;
            rd_addr <= ocl.araddr[15:0];
        end else if (ar_q) begin
            ar_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
        end else if (rvalid_q && ocl.rready) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) vled <= '0;
        else             vled <= result_q[0][15:0];
    end

    logic unused_bits;
    assign unused_bits = ^{ocl.awaddr[31:16], ocl.araddr[31:16], wr_addr[1:0], rd_addr[1:0]};

endmodule
